fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, fetch address width in words.
REQ-002 SHALL provide parameter DATA_W, default 32, opcode width.
REQ-003 SHALL provide parameter DEPTH, default 4, prefetch queue entries; legal values are powers of two, minimum 2.
REQ-004 SHALL provide parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-005 SHALL have the port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have the port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have the port en  in  1  stage enable; low freezes all state.
REQ-008 SHALL have the port stop  in  1  suppresses new fetch requests; the queue output keeps draining.
REQ-009 SHALL have the port jump  in  1  redirect strobe.
REQ-010 SHALL have the port newFetchAddr  in  32  redirect target; bits [ADDR_W-1:0] are used.
REQ-011 SHALL have the port fetchaddr  out  ADDR_W  instruction memory word address (the current PC).
REQ-012 SHALL have the port fetch_req  out  1  memory read issued this cycle.
REQ-013 SHALL have the port data  in  DATA_W  memory read data, valid exactly one enabled cycle after fetch_req.
REQ-014 SHALL have the port opcode  out  DATA_W  opcode at the queue head.
REQ-015 SHALL have the port curropcodePC  out  32  PC of the head opcode, zero-extended.
REQ-016 SHALL have the port op_valid  out  1  head entry is valid.
REQ-017 SHALL have the port op_ready  in  1  consumer accepts the head entry.
REQ-018 SHALL have the port queue_count  out  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-019 SHALL assert fetch_req when en and !stop and !jump and (queue_count + inflight) < DEPTH, where inflight is a 1-bit pending-response flag.
REQ-020 SHALL, on each issued request, set PC to (PC+1) mod 2^ADDR_W, set inflight, and record the issued PC as the response tag; wrap from all-ones to 0 SHALL occur without error.
REQ-021 SHALL, in the enabled cycle following a request, write {tag, data} to the queue tail and clear inflight, unless jump is high in that cycle.
REQ-022 SHALL drive op_valid = (queue_count != 0), and SHALL drive opcode and curropcodePC to 0 while op_valid is low.
REQ-023 SHALL pop the head when en and op_valid and op_ready are all high.
REQ-024 SHALL, on a simultaneous push and pop, leave queue_count unchanged; a pop from an empty queue SHALL be impossible.
REQ-025 SHALL, on jump with en high: load PC with newFetchAddr[ADDR_W-1:0], empty the queue, clear inflight, discard any response arriving that cycle, and issue no request that cycle.
REQ-026 SHALL give jump priority over stop; a pop accepted in the jump cycle SHALL count as consumed.
REQ-027 SHALL take 2 cycles from request to op_valid; with DEPTH>=3, op_ready held high and stop low, SHALL deliver one opcode per cycle.
REQ-028 SHALL, with en low, force fetch_req low and hold the PC, queue, inflight and counters; the memory holds data under the same en.

Reset
REQ-029 SHALL, on rst high at a clock edge, set PC=RESET_ADDR, queue_count=0, pointers=0, inflight=0 and op_valid=0; rst SHALL override en and jump.
REQ-030 SHALL, on reset applied mid-operation, drop all queued and in-flight opcodes, and SHALL issue the first request at RESET_ADDR in the first cycle after rst falls.

Configuration
REQ-031 SHALL, with FETCH_PERF_CNT_EN defined, add the outputs perf_fetched (32, count of pops) and perf_flushes (32, count of jump cycles with en), both cleared by rst and wrapping at 2^32.
REQ-032 SHALL, without FETCH_PERF_CNT_EN, omit both ports and both counters, with no other behavioural difference.

Verification
REQ-033 The bench SHALL cover: rst release, RESET_ADDR=0, op_ready=1, memory returns addr+0x100 -> op_valid in cycle 2, opcodes 0x100, 0x101, ... one per cycle, curropcodePC 0, 1, 2, ...
REQ-034 The bench SHALL cover: op_ready=0 for 10 cycles, DEPTH=4 -> queue_count saturates at 4, fetch_req low, fetchaddr=4.
REQ-035 The bench SHALL cover: jump with newFetchAddr=0x20 while the queue holds 3 entries and a request is in flight -> next cycle op_valid=0, fetchaddr=0x20, and the first opcode after the jump carries curropcodePC=0x20.
REQ-036 The bench SHALL cover: PC=0x3FFF (ADDR_W=14), fetching -> next fetchaddr=0x0000, curropcodePC sequence 0x3FFF then 0x0000.
REQ-037 The bench SHALL cover: stop=1 with 2 entries queued and op_ready=1 -> both opcodes drain, no fetch_req, PC unchanged; stop=0 -> fetching resumes at the held PC.
REQ-038 The bench SHALL cover: en=0 for 5 cycles mid-stream -> all outputs static; with FETCH_PERF_CNT_EN defined, perf counters unchanged across the window.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a small prefetch queue.
// Issues sequential word fetches and tags each memory response with the PC
// it was issued for. Responses go into a DEPTH-entry FIFO that feeds the
// consumer. A jump redirects the PC and flushes the FIFO.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched and
// perf_flushes counters.
module fetch_queue #(
    parameter int          ADDR_W     = 14,
    parameter int          DATA_W     = 32,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         stop,
    input  logic                         jump,
    input  logic [31:0]                  newFetchAddr,
    output logic [ADDR_W-1:0]            fetchaddr,
    output logic                         fetch_req,
    input  logic [DATA_W-1:0]            data,
    output logic [DATA_W-1:0]            opcode,
    output logic [31:0]                  curropcodePC,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_flushes
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0] tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Only the low ADDR_W bits of the redirect target form the PC.
    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^newFetchAddr[31:ADDR_W];
    end

    // Queue entries plus the pending response must leave room for one more.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign fetch_req   = en & ~stop & ~jump & (occupancy < DEPTH_C);
    assign push        = en & inflight & ~jump;
    assign op_valid    = (count != '0);
    assign pop         = en & op_valid & op_ready;
    assign fetchaddr   = pc;
    assign queue_count = count;

    // Head presentation, zeroed while the queue is empty.
    always_comb begin
        opcode       = '0;
        curropcodePC = '0;
        if (op_valid) begin
            opcode       = data_mem[rd_ptr];
            curropcodePC = 32'(tag_mem[rd_ptr]);
        end
    end

    // FIFO storage: capture the tagged memory response at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= tag;
            data_mem[wr_ptr] <= data;
        end
    end

    // PC, in-flight tracking and queue bookkeeping; jump flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= ADDR_W'(RESET_ADDR);
            tag      <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (en) begin
            if (jump) begin
                pc       <= newFetchAddr[ADDR_W-1:0];
                inflight <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                // A response lands every cycle after a request, so the
                // pending flag simply follows this cycle's request.
                inflight <= fetch_req;
                if (fetch_req) begin
                    pc  <= pc + ADDR_W'(1);
                    tag <= pc;
                end
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: consumed opcodes and enabled jump cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else if (en) begin
            if (pop)  perf_fetched <= perf_fetched + 32'd1;
            if (jump) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule
